// File: rtl/ofifo.sv
// ofifo: per-column output FIFO that realigns skewed systolic psum columns into whole rows.
module ofifo #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   hold,
  output logic                   ofifo_valid,
  output logic [psum_bw*col-1:0] ofifo_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   overflow,
  output logic [7:0]             row_cnt
);
  localparam int lw = $clog2(depth);
  localparam logic [lw:0] one = 1;
  logic [psum_bw-1:0] mem [col][depth];
  logic [lw:0] wptr_q [col];
  logic [lw:0] wptr_d [col];
  logic [lw:0] rptr_q [col];
  logic [lw:0] rptr_d [col];
  logic [lw:0] cnt [col];
  logic [col-1:0] wacc;
  logic row_avail, pop;
  logic valid_q, valid_d, ovf_q, ovf_d;
  logic [psum_bw*col-1:0] data_q, data_d;
  logic [7:0] rcnt_q, rcnt_d;
  always_comb begin
    row_avail = 1'b1;
    o_full    = 1'b0;
    o_empty   = 1'b1;
    for (int c = 0; c < col; c++) begin
      cnt[c] = wptr_q[c] - rptr_q[c];
      row_avail = row_avail & (cnt[c] != '0);
      o_full    = o_full | cnt[c][lw];
      o_empty   = o_empty & (cnt[c] == '0);
    end
    pop     = row_avail & ~hold;
    data_d  = data_q;
    ovf_d   = ovf_q;
    valid_d = pop;
    rcnt_d  = pop ? rcnt_q + 8'd1 : rcnt_q;
    for (int c = 0; c < col; c++) begin
      // a full column may still accept a write when the same edge pops it
      wacc[c]   = wr[c] & (~cnt[c][lw] | pop);
      ovf_d     = ovf_d | (wr[c] & ~wacc[c]);
      wptr_d[c] = wacc[c] ? wptr_q[c] + one : wptr_q[c];
      rptr_d[c] = pop ? rptr_q[c] + one : rptr_q[c];
      if (pop) data_d[psum_bw*c +: psum_bw] = mem[c][rptr_q[c][lw-1:0]];
    end
  end
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++)
      if (wacc[c]) mem[c][wptr_q[c][lw-1:0]] <= in[psum_bw*c +: psum_bw];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
      end
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      rcnt_q  <= rcnt_d;
    end
  end
  assign ofifo_valid = valid_q;
  assign ofifo_data  = data_q;
  assign overflow    = ovf_q;
  assign row_cnt     = rcnt_q;
endmodule

// File: tb/tb_ofifo.sv
// tb_ofifo: directed table and sequence checks for the ofifo row realigner.
module tb_ofifo;
  logic clk = 1'b0, reset = 1'b0, hold = 1'b0;
  logic [127:0] in = '0;
  logic [7:0] wr = '0;
  logic ofifo_valid, o_full, o_empty, overflow;
  logic [127:0] ofifo_data;
  logic [7:0] row_cnt;
  int checks = 0, errors = 0;

  ofifo dut (.clk(clk), .reset(reset), .in(in), .wr(wr), .hold(hold),
             .ofifo_valid(ofifo_valid), .ofifo_data(ofifo_data), .o_full(o_full),
             .o_empty(o_empty), .overflow(overflow), .row_cnt(row_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   wr;
    logic         hold;
    logic         ev;
    logic [127:0] ed;
    logic [7:0]   erc;
    logic         eempty;
    logic         efull;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr = '0; hold = 1'b0; in = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [127:0] rep(input int r);
    logic [127:0] d;
    for (int c = 0; c < 8; c++) d[16*c +: 16] = 16'(r);
    return d;
  endfunction

  vec_t tbl [10];
  logic [127:0] skew_row;
  int first, nrow, gaps, k;

  initial begin
    for (int c = 0; c < 8; c++) skew_row[16*c +: 16] = 16'(c + 1);
    for (int i = 0; i < 8; i++) tbl[i] = '{8'(1 << i), 1'b0, 1'b0, 128'd0, 8'd0, 1'b0, 1'b0};
    tbl[8] = '{8'h00, 1'b0, 1'b1, skew_row, 8'd1, 1'b1, 1'b0};
    tbl[9] = '{8'h00, 1'b0, 1'b0, skew_row, 8'd1, 1'b1, 1'b0};

    // reset state
    reset = 1'b1;
    #3;
    chk("rst_valid", 128'(ofifo_valid), 128'd0);
    chk("rst_data", ofifo_data, 128'd0);
    chk("rst_rowcnt", 128'(row_cnt), 128'd0);
    chk("rst_empty", 128'(o_empty), 128'd1);
    chk("rst_full", 128'(o_full), 128'd0);
    chk("rst_ovf", 128'(overflow), 128'd0);
    tick();
    reset = 1'b0;

    // skewed single-row fill
    for (int i = 0; i < 10; i++) begin
      wr = tbl[i].wr; hold = tbl[i].hold; in = skew_row;
      tick();
      chk($sformatf("skew%0d_valid", i), 128'(ofifo_valid), 128'(tbl[i].ev));
      chk($sformatf("skew%0d_data", i), ofifo_data, tbl[i].ed);
      chk($sformatf("skew%0d_rowcnt", i), 128'(row_cnt), 128'(tbl[i].erc));
      chk($sformatf("skew%0d_empty", i), 128'(o_empty), 128'(tbl[i].eempty));
      chk($sformatf("skew%0d_full", i), 128'(o_full), 128'(tbl[i].efull));
    end

    // 36-row skewed stream
    do_reset();
    first = -1; nrow = 0; gaps = 0;
    for (int t = 0; t < 48; t++) begin
      for (int c = 0; c < 8; c++) begin
        wr[c] = (t - c >= 0) && (t - c < 36);
        in[16*c +: 16] = 16'(t - c);
      end
      tick();
      if (ofifo_valid) begin
        chk($sformatf("stream_row%0d", nrow), ofifo_data, rep(nrow));
        if (nrow == 0) first = t;
        nrow++;
      end else if (nrow > 0 && nrow < 36) gaps++;
    end
    wr = '0;
    chk("stream_first", 128'(first), 128'd8);
    chk("stream_rows", 128'(nrow), 128'd36);
    chk("stream_gaps", 128'(gaps), 128'd0);
    chk("stream_rowcnt", 128'(row_cnt), 128'd36);
    chk("stream_empty", 128'(o_empty), 128'd1);

    // hold while three rows arrive, then release
    do_reset();
    hold = 1'b1;
    k = 0;
    for (int r = 0; r < 5; r++) begin
      wr = (r < 3) ? 8'hFF : 8'h00;
      in = rep(r);
      tick();
      if (ofifo_valid) k++;
    end
    chk("hold_novalid", 128'(k), 128'd0);
    hold = 1'b0; wr = '0;
    for (int r = 0; r < 3; r++) begin
      tick();
      chk($sformatf("hold_v%0d", r), 128'(ofifo_valid), 128'd1);
      chk($sformatf("hold_d%0d", r), ofifo_data, rep(r));
    end
    tick();
    chk("hold_after", 128'(ofifo_valid), 128'd0);
    chk("hold_rowcnt", 128'(row_cnt), 128'd3);

    // column 0 to depth, overflow, then drain column 0
    do_reset();
    for (int i = 0; i < 64; i++) begin
      wr = 8'h01; in = '0; in[15:0] = 16'(100 + i);
      tick();
    end
    chk("full_set", 128'(o_full), 128'd1);
    chk("full_noovf", 128'(overflow), 128'd0);
    in[15:0] = 16'd999;
    tick();
    chk("ovf_set", 128'(overflow), 128'd1);
    chk("ovf_full", 128'(o_full), 128'd1);
    nrow = 0;
    for (int t = 0; t < 70; t++) begin
      wr = (t < 64) ? 8'hFE : 8'h00;
      in = rep(t);
      tick();
      if (ofifo_valid) begin
        chk($sformatf("drain%0d", nrow), 128'(ofifo_data[15:0]), 128'(100 + nrow));
        nrow++;
      end
    end
    wr = '0;
    chk("drain_rows", 128'(nrow), 128'd64);
    chk("drain_empty", 128'(o_empty), 128'd1);
    chk("drain_ovf_sticky", 128'(overflow), 128'd1);

    // full column written on a pop edge
    do_reset();
    for (int i = 0; i < 64; i++) begin
      wr = 8'h01; in = rep(i);
      tick();
    end
    wr = 8'hFE;
    tick();
    wr = 8'hFF; in = rep(77);
    tick();
    wr = '0;
    chk("popwr_valid", 128'(ofifo_valid), 128'd1);
    chk("popwr_ovf", 128'(overflow), 128'd0);
    chk("popwr_full", 128'(o_full), 128'd1);

    // asynchronous reset mid-stream
    do_reset();
    nrow = 0;
    for (int t = 0; t < 10 && nrow < 5; t++) begin
      wr = 8'hFF; in = rep(t + 1);
      tick();
      if (ofifo_valid) nrow++;
    end
    chk("mid_rows", 128'(nrow), 128'd5);
    wr = '0;
    #2 reset = 1'b1;
    #1;
    chk("mid_valid", 128'(ofifo_valid), 128'd0);
    chk("mid_data", ofifo_data, 128'd0);
    chk("mid_rowcnt", 128'(row_cnt), 128'd0);
    chk("mid_empty", 128'(o_empty), 128'd1);
    tick();
    reset = 1'b0;
    k = 0;
    for (int t = 0; t < 4; t++) begin
      wr = (t == 0) ? 8'h7F : 8'h00; in = rep(50);
      tick();
      if (ofifo_valid) k++;
    end
    chk("mid_noval", 128'(k), 128'd0);
    wr = 8'h80;
    tick();
    wr = '0;
    tick();
    chk("mid_refill_valid", 128'(ofifo_valid), 128'd1);
    chk("mid_refill_data", ofifo_data, rep(50));
    chk("mid_refill_rowcnt", 128'(row_cnt), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
